// File: rtl/ram_bist.sv
// March-style RAM self test: writes pattern(k) = (2k) mod 254 to every
// location, reads everything back, counts mismatches and records the first
// failing address. All outputs are registered.
module ram_bist #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_data_in,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_data_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE:0]   err_count,
  output logic [ADDR_SIZE-1:0] first_err_addr
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // WRITE | writing pattern(k) to address k, k = 0..MEM_DEPTH-1
  // READ  | reading address k and comparing against pattern(k)
  // DONE  | results valid and held, waiting for start
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t state, state_nxt;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE+1:0] PAT_MOD   = (ADDR_SIZE + 2)'(254);

  function automatic logic [WORD_SIZE-1:0] pattern(input logic [ADDR_SIZE-1:0] k);
    logic [ADDR_SIZE+1:0] p;
    p = ({2'b00, k} << 1) % PAT_MOD;
    return WORD_SIZE'(p);
  endfunction

  logic                 at_last;
  logic                 mismatch;
  logic                 launch;
  logic [ADDR_SIZE-1:0] addr_inc;

  assign at_last  = (ram_addr == LAST_ADDR);
  assign addr_inc = ram_addr + 1'b1;
  assign mismatch = (ram_data_out != pattern(ram_addr));
  // start is only honoured while no test is running
  assign launch   = start && ((state == IDLE) || (state == DONE));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)   state_nxt = WRITE;
      WRITE:   if (at_last) state_nxt = READ;
      READ:    if (at_last) state_nxt = DONE;
      DONE:    if (start)   state_nxt = WRITE;
      default:              state_nxt = IDLE;
    endcase
  end

  // registered RAM interface, address counter and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr       <= '0;
      ram_data_in    <= '0;
      ram_wr         <= 1'b0;
      ram_cs         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (launch) begin
      ram_addr       <= '0;
      ram_data_in    <= pattern('0);
      ram_wr         <= 1'b1;
      ram_cs         <= 1'b1;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        WRITE: begin
          if (at_last) begin
            ram_addr <= '0;
            ram_wr   <= 1'b0;
          end else begin
            ram_addr    <= addr_inc;
            ram_data_in <= pattern(addr_inc);
          end
        end
        READ: begin
          if (mismatch) begin
            err_count <= err_count + 1'b1;
            if (err_count == '0) first_err_addr <= ram_addr;
          end
          if (at_last) begin
            ram_cs <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            // include the compare happening on this very edge
            pass   <= (err_count == '0) && !mismatch;
          end else begin
            ram_addr <= addr_inc;
          end
        end
        default: begin
          ram_wr <= 1'b0;
          ram_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: behavioural RAM with optional stuck-at-1 on bit 0 and
// per-address corruption applied once the read pass begins.
// Edges are numbered with the start-sampling edge as edge 1.
module tb_ram_bist;

  localparam int AW    = 10;
  localparam int WW    = 8;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] ram_addr;
  logic [WW-1:0] ram_data_in;
  logic          ram_wr;
  logic          ram_cs;
  logic [WW-1:0] ram_data_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  ram_bist #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_wr(ram_wr),
    .ram_cs(ram_cs), .ram_data_out(ram_data_out),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic int pat(input int k);
    return (2 * k) % 254;
  endfunction

  // RAM model
  logic [WW-1:0] mem      [DEPTH];
  bit            ovr_en   [DEPTH];
  logic [WW-1:0] ovr_val  [DEPTH];
  bit            pend_en  [DEPTH];
  logic [WW-1:0] pend_val [DEPTH];
  bit            stuck;
  int            wr_total = 0;
  int            wr_bad   = 0;
  int            wr_base  = 0;

  always_comb begin
    ram_data_out = ovr_en[ram_addr] ? ovr_val[ram_addr] : mem[ram_addr];
    if (stuck) ram_data_out[0] = 1'b1;
  end

  // write port plus in-order check of every write seen
  always @(posedge clk) begin
    if (ram_cs && ram_wr) begin
      mem[ram_addr] <= ram_data_in;
      if (int'(ram_addr) != (wr_total - wr_base) ||
          int'(ram_data_in) != pat(wr_total - wr_base)) wr_bad++;
      wr_total++;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_pend();
    for (int i = 0; i < DEPTH; i++) begin
      pend_en[i]  = 1'b0;
      pend_val[i] = '0;
    end
  endtask

  // pulse start, run to done, check timing, writes and hold behaviour
  task automatic run_bist(input bit repulse, input string tag);
    int  edge_n;
    int  bad_base;
    bit  applied;
    bit  got;
    for (int i = 0; i < DEPTH; i++) ovr_en[i] = 1'b0;
    wr_base  = wr_total;
    bad_base = wr_bad;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    edge_n = 1;
    #1 start = 1'b0;
    check({tag, " launch busy"}, int'(busy), 1);
    check({tag, " launch done"}, int'(done), 0);
    check({tag, " launch pass"}, int'(pass), 0);
    check({tag, " launch err_count"}, int'(err_count), 0);
    check({tag, " launch first_err"}, int'(first_err_addr), 0);
    check({tag, " launch wr/cs"}, int'({ram_wr, ram_cs}), 3);
    check({tag, " launch addr"}, int'(ram_addr), 0);
    applied = 1'b0;
    got     = 1'b0;
    while (!got && edge_n < 3000) begin
      if (repulse && edge_n == 499) start = 1'b1;
      @(posedge clk);
      edge_n++;
      #1;
      if (repulse && edge_n == 500) begin
        start = 1'b0;
        check({tag, " start ignored addr"}, int'(ram_addr), 499);
        check({tag, " start ignored busy"}, int'(busy), 1);
      end
      if (!applied && busy && !ram_wr) begin
        applied = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          ovr_en[i]  = pend_en[i];
          ovr_val[i] = pend_val[i];
        end
      end
      if (done) got = 1'b1;
    end
    check({tag, " done reached"}, int'(got), 1);
    check({tag, " done edge"}, edge_n, 2 * DEPTH + 1);
    check({tag, " write count"}, wr_total - wr_base, DEPTH);
    check({tag, " bad writes"}, wr_bad - bad_base, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, " hold done/busy"}, int'({done, busy}), 2);
    check({tag, " hold wr/cs"}, int'({ram_wr, ram_cs}), 0);
    check({tag, " hold addr"}, int'(ram_addr), DEPTH - 1);
  endtask

  typedef struct {
    bit          stuck;
    bit          corr_en;
    int          corr_addr;
    logic [7:0]  corr_val;
    bit          repulse;
    int          exp_err;
    int          exp_first;
    bit          exp_pass;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int exp_err;
    int exp_first;
    int w;
    int edge_n;
    vecs[0] = '{0, 0, 0,    8'h00, 0, 0,    0,    1};  // fault free
    vecs[1] = '{0, 1, 37,   8'hFF, 0, 1,    37,   0};  // overwritten word
    vecs[2] = '{1, 0, 0,    8'h00, 0, 1024, 0,    0};  // bit0 stuck at 1
    vecs[3] = '{0, 0, 0,    8'h00, 1, 0,    0,    1};  // rerun clears, start ignored
    vecs[4] = '{0, 1, 1023, 8'hFE, 0, 1,    1023, 0};  // last address (pattern 14)
    vecs[5] = '{0, 1, 127,  8'h00, 0, 0,    0,    1};  // same value as pattern(127)
    vecs[6] = '{0, 1, 0,    8'h01, 0, 1,    0,    0};  // failure at address 0

    rst_n = 1'b0;
    start = 1'b0;
    stuck = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0; ovr_en[i] = 1'b0; ovr_val[i] = '0;
    end
    clear_pend();
    repeat (3) @(posedge clk);
    #1;
    check("reset busy/done/pass", int'({busy, done, pass}), 0);
    check("reset wr/cs", int'({ram_wr, ram_cs}), 0);
    check("reset addr/data", int'(ram_addr) + int'(ram_data_in), 0);
    check("reset results", int'(err_count) + int'(first_err_addr), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle stays idle", int'({busy, done, ram_cs}), 0);

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      clear_pend();
      stuck = vecs[v].stuck;
      if (vecs[v].corr_en) begin
        pend_en[vecs[v].corr_addr]  = 1'b1;
        pend_val[vecs[v].corr_addr] = vecs[v].corr_val;
      end
      run_bist(vecs[v].repulse, tag);
      check({tag, " err_count"}, int'(err_count), vecs[v].exp_err);
      check({tag, " first_err"}, int'(first_err_addr), vecs[v].exp_first);
      check({tag, " pass"}, int'(pass), int'(vecs[v].exp_pass));
    end
    stuck = 1'b0;

    // randomized corruption sets against an arithmetic reference
    for (int r = 0; r < 4; r++) begin
      string tag;
      int n;
      tag = $sformatf("rand%0d", r);
      clear_pend();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        int a;
        a = $urandom_range(0, DEPTH - 1);
        pend_en[a]  = 1'b1;
        pend_val[a] = ($urandom_range(0, 3) == 0) ? WW'(pat(a)) : WW'($urandom_range(0, 255));
      end
      exp_err   = 0;
      exp_first = 0;
      for (int k = 0; k < DEPTH; k++) begin
        if (pend_en[k] && int'(pend_val[k]) != pat(k)) begin
          if (exp_err == 0) exp_first = k;
          exp_err++;
        end
      end
      run_bist(1'b0, tag);
      check({tag, " err_count"}, int'(err_count), exp_err);
      check({tag, " first_err"}, int'(first_err_addr), exp_first);
      check({tag, " pass"}, int'(pass), int'(exp_err == 0));
    end

    // reset in the middle of the write pass
    clear_pend();
    for (int i = 0; i < DEPTH; i++) ovr_en[i] = 1'b0;
    wr_base = wr_total;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    edge_n = 1;
    #1 start = 1'b0;
    while (edge_n < 301) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
    check("abort point addr", int'(ram_addr), 300);
    check("abort point wr", int'(ram_wr), 1);
    rst_n = 1'b0;
    #1;
    check("abort busy/done/pass", int'({busy, done, pass}), 0);
    check("abort wr/cs", int'({ram_wr, ram_cs}), 0);
    check("abort addr/data", int'(ram_addr) + int'(ram_data_in), 0);
    check("abort results", int'(err_count) + int'(first_err_addr), 0);
    w = wr_total;
    repeat (5) @(posedge clk);
    #1;
    check("writes before abort", w - wr_base, 300);
    check("no writes in reset", wr_total - w, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_bist(1'b0, "after_abort");
    check("after_abort err_count", int'(err_count), 0);
    check("after_abort pass", int'(pass), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
